// File: rtl/edge_arb_pkg.sv
// Shared types and helpers for the edge-event arbiter family.
package edge_arb_pkg;

  // Arbiter FSM: IDLE picks the next pending channel, OFFER holds it until accepted.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  // Default number of input channels.
  localparam int DEF_N = 4;

  // Width of a channel index for n channels; never less than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int k = 1; k < 6; k++) begin
      if ((1 << k) < n) w = k + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event output port of the edge-event arbiter.
//
// Handshake: an event transfers at the rising clk edge where evt_valid and
// evt_ready are both 1. While evt_valid is 1 the producer keeps evt_id stable
// and never withdraws the offer; the consumer may raise or drop evt_ready at
// any time, which only decides the cycle of transfer.
interface edge_event_arbiter_if #(
  parameter int IDW = 2
);
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );
endinterface

// File: rtl/edge_arb_rr_pick.sv
// Combinational round-robin search: first set bit of pend_i, scanning
// ptr_i, ptr_i+1, ... N-1, 0, ... ptr_i-1. N need not be a power of two.
module edge_arb_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   pend_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o
);

  int cand;

  // Walk the channels in rotated order and keep the first pending one.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (!found_o && pend_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge event latch with a round-robin shared event output and
// per-channel sticky overrun flags.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int IDW = idx_width(N)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N-1:0]                x,
  input  logic [N-1:0]                mask,
  edge_event_arbiter_if.master        evt,
  input  logic                        ovr_clr,
  output logic [N-1:0]                pending,
  output logic [N-1:0]                overrun,
  output arb_state_t                  dbg_state_o,
  output logic [IDW-1:0]              dbg_ptr_o
);

  logic [N-1:0]   prev_q;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   overrun_q, overrun_d;
  logic [N-1:0]   edge_v;
  logic [N-1:0]   acc_v;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] id_q;
  logic           valid_q;
  arb_state_t     state_q;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;

  edge_arb_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .pend_i  (pending_q),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Edge detect, acceptance decode and next pending/overrun vectors.
  // A fresh edge on the channel being consumed re-arms it instead of overrunning.
  always_comb begin
    edge_v = x & ~prev_q & mask;
    acc_v  = '0;
    if (valid_q && evt.evt_ready) acc_v[id_q] = 1'b1;
    pending_d = edge_v | (pending_q & ~acc_v);
    overrun_d = (ovr_clr ? '0 : overrun_q) | (edge_v & pending_q & ~acc_v);
  end

  // Sample history and event flags; prev starts all ones so lines already
  // high at reset release are not seen as edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= '1;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      prev_q    <= x;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Arbiter FSM with registered offer outputs and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            id_q    <= pick_idx;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (evt.evt_ready) begin
            ptr_q   <= (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = id_q;
  assign pending       = pending_q;
  assign overrun       = overrun_q;
  assign dbg_state_o   = state_q;
  assign dbg_ptr_o     = ptr_q;

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

- Watches N asynchronous-to-nothing (already synchronised) level inputs and detects a rising edge (0→1) on each.
- Latches each edge as a pending event and shares one event output port between the channels by round-robin.
- The output uses a valid/ready handshake.
- Sits between the positive-edge detection datapath and a single downstream event consumer (interrupt/sequencer logic), and reports lost events as per-channel sticky overruns.

## Interface
- N, 4, number of input channels (2..16)
- IDW, $clog2(N), width of channel index
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- x  in  N  channel levels, synchronous to clk
- mask  in  N  1 = edge detection enabled for channel
- evt_valid  out  1  event offered
- evt_id  out  IDW  channel index of offered event
- evt_ready  in  1  consumer accepts offered event
- pending  out  N  registered pending-event flags
- overrun  out  N  sticky: an edge was lost on channel
- ovr_clr  in  1  pulse; clears all overrun bits

## Operation
- Reset values:
  - evt_valid=0, evt_id=0, pending=0, overrun=0.
  - Round-robin pointer ptr=0, FSM=IDLE.
  - Previous-sample register prev=all ones, so lines already high at reset release do not report an edge.
- Edge detection per channel i: edge[i] = x[i] & ~prev[i] & mask[i]; prev <= x every cycle, regardless of mask.
- Pending update per channel, evaluated in priority order:
  - edge[i] and pending[i] set and not being accepted this cycle: overrun[i] <= 1, pending stays 1.
  - edge[i] and accepted this cycle: pending stays 1 (the new edge replaces the consumed one), no overrun.
  - accepted this cycle, no edge: pending[i] <= 0.
  - edge[i], pending[i]=0: pending[i] <= 1.
- Clearing mask[i] does not clear pending[i]; already-latched events are still delivered.
- FSM states:
  - IDLE:
    - if pending != 0, select the first set bit searching ptr, ptr+1, … N-1, 0, … ptr-1.
    - evt_id <= that index, evt_valid <= 1, go OFFER; else stay.
  - OFFER:
    - evt_valid=1, evt_id held stable.
    - on evt_valid & evt_ready: pending[evt_id] cleared (subject to the edge rule above), ptr <= (evt_id+1) mod N, evt_valid <= 0, go IDLE.
    - else stay.
- The offered event is never withdrawn or changed while evt_valid=1, even if a higher-priority channel becomes pending.
- Overrun bits:
  - ovr_clr clears all overrun bits.
  - A new overrun in the same cycle as ovr_clr wins, and that bit stays 1.
- ptr wraps N-1 → 0; N need not be a power of two, and indices ≥N are never produced.

## Timing
- Edge latency: x[i] first sampled high at posedge t, with prev 0 → pending[i]=1 after t → FSM latches at t+1 → evt_valid=1 after t+1 (2 cycles).
- Handshake completes at the posedge where evt_valid & evt_ready are both 1. evt_valid is 0 for at least one cycle afterwards (IDLE bubble).
- Maximum throughput is one event per 2 cycles.
- evt_ready may be held high permanently. The consumer may drop ready at any time without effect on the offer.
- Asynchronous reset mid-offer drops the offered event and all pending events immediately; the outputs take their reset values without waiting for a clock edge.

## Structure
- Shared package edge_arb_pkg holds:
  - typedef enum {IDLE, OFFER} arb_state_t
  - default N constant
  - index-width helper function
- Sub-module edge_arb_rr_pick:
  - purely combinational round-robin search.
  - inputs: pending vector, ptr.
  - outputs: found flag, index.
  - reused by other arbiters in the codebase.
- Top holds prev, pending, overrun, ptr, FSM and output registers.

## Test plan
- Reset release with x=4'b0101 held, mask=4'hF → no pending, evt_valid stays 0 for 10 cycles.
- Single edge on x[2], evt_ready=1 → evt_valid rises 2 cycles after the edge sample with evt_id=2, drops the next cycle, pending=0.
- Edges on channels 0,1,3 in the same cycle, ready=1, ptr=0 → ids delivered 0,1,3, each 2 cycles apart; ptr ends at 0.
- evt_ready=0 while offering id 1, second edge on x[1] → overrun[1]=1, pending[1] stays 1; ovr_clr → overrun=0.
- Edge on x[1] in the exact cycle id 1 is accepted → pending[1] remains 1, id 1 offered again, overrun[1]=0.
- Assert reset mid-offer with pending=4'b1010 → evt_valid, pending and ptr clear asynchronously; x[0] masked off → its edges are ignored.
